// File: rtl/nv_nvdla_mcif_csb_reg_gen_pkg.sv
// Shared constants for the MCIF CSB register block: offsets, reset values, apply FSM states, ERR bit indices.
// No logic; imported by the top and the interface users.
package nv_nvdla_mcif_csb_pkg;

  localparam logic [11:0] RD_WEIGHT_BASE = 12'h000;
  localparam logic [11:0] WR_WEIGHT_BASE = 12'h040;
  localparam logic [11:0] OS_CNT_OFS     = 12'h080;
  localparam logic [11:0] STATUS_OFS     = 12'h084;
  localparam logic [11:0] ERR_OFS        = 12'h088;
  localparam logic [11:0] RD_REQ_CNT_OFS = 12'h08C;
  localparam logic [11:0] WR_REQ_CNT_OFS = 12'h090;

  localparam logic [7:0] WEIGHT_RST = 8'h01;
  localparam logic [7:0] OS_LIM_RST = 8'hFF;

  typedef enum logic {
    ST_SYNC    = 1'b0,
    ST_PENDING = 1'b1
  } apply_st_e;

  localparam int ERR_RD_OVF = 0;
  localparam int ERR_RD_UNF = 1;
  localparam int ERR_WR_OVF = 2;
  localparam int ERR_WR_UNF = 3;

endpackage

// File: rtl/nv_nvdla_mcif_csb_reg_gen_if.sv
// CSB slave-side register bus: 12b byte offset, single-cycle write strobe, combinational read data.
// No handshake; every access completes in the cycle it is presented.
interface nv_nvdla_mcif_csb_reg_gen_if;
  logic [11:0] reg_offset;
  logic [31:0] reg_wr_data;
  logic        reg_wr_en;
  logic [31:0] reg_rd_data;

  modport master (output reg_offset, reg_wr_data, reg_wr_en, input reg_rd_data);
  modport slave  (input reg_offset, reg_wr_data, reg_wr_en, output reg_rd_data);
endinterface

// File: rtl/nv_nvdla_mcif_os_tracker.sv
// Saturating up/down counter of live outstanding requests; count updates at the next edge.
// ovf/unf are combinational pulses in the cycle of the offending event; no backpressure.
module nv_nvdla_mcif_os_tracker #(
  parameter int OS_CNT_W = 8
) (
  input  logic                nvdla_core_clk,
  input  logic                nvdla_core_rstn,
  input  logic                issue,
  input  logic                done,
  output logic [OS_CNT_W-1:0] cnt,
  output logic                ovf,
  output logic                unf
);

  // simultaneous issue and done cancel out and never flag an error
  assign ovf = issue && !done && (cnt == {OS_CNT_W{1'b1}});
  assign unf = done && !issue && (cnt == '0);

  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) begin
      cnt <= '0;
    end else if (issue && !done && !ovf) begin
      cnt <= cnt + 1'b1;
    end else if (done && !issue && !unf) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/nv_nvdla_mcif_csb_reg_gen.sv
// MCIF arbiter CSB registers: shadow weights/limits copied to active outputs once the MCIF is quiescent.
// Reads are combinational; MCIF_CSB_PERF_EN adds rd/wr request counters at 0x08C/0x090.
module nv_nvdla_mcif_csb_reg_gen
  import nv_nvdla_mcif_csb_pkg::*;
#(
  parameter int NUM_RD   = 12,
  parameter int NUM_WR   = 8,
  parameter int OS_CNT_W = 8
) (
  input  logic                           nvdla_core_clk,
  input  logic                           nvdla_core_rstn,
  nv_nvdla_mcif_csb_reg_gen_if.slave     csb,
  input  logic                           idle,
  input  logic                           rd_req_issue,
  input  logic                           rd_rsp_done,
  input  logic                           wr_req_issue,
  input  logic                           wr_rsp_done,
  output logic [8*NUM_RD-1:0]            rd_weight,
  output logic [8*NUM_WR-1:0]            wr_weight,
  output logic [OS_CNT_W-1:0]            rd_os_cnt,
  output logic [OS_CNT_W-1:0]            wr_os_cnt,
  output logic                           err_intr
);

  logic [8*NUM_RD-1:0] rd_wt_shd, rd_wt_nxt;
  logic [8*NUM_WR-1:0] wr_wt_shd, wr_wt_nxt;
  logic [OS_CNT_W-1:0] rd_lim_shd, rd_lim_nxt, wr_lim_shd, wr_lim_nxt;
  logic [OS_CNT_W-1:0] rd_live, wr_live;
  logic                rd_ovf, rd_unf, wr_ovf, wr_unf;
  logic [3:0]          err, err_set, err_clr;
  logic [31:0]         rd_data;
  logic                cfg_wr, apply_ok;
  apply_st_e           state;

  nv_nvdla_mcif_os_tracker #(.OS_CNT_W(OS_CNT_W)) u_rd_trk (
    .nvdla_core_clk (nvdla_core_clk), .nvdla_core_rstn (nvdla_core_rstn),
    .issue (rd_req_issue), .done (rd_rsp_done), .cnt (rd_live), .ovf (rd_ovf), .unf (rd_unf)
  );

  nv_nvdla_mcif_os_tracker #(.OS_CNT_W(OS_CNT_W)) u_wr_trk (
    .nvdla_core_clk (nvdla_core_clk), .nvdla_core_rstn (nvdla_core_rstn),
    .issue (wr_req_issue), .done (wr_rsp_done), .cnt (wr_live), .ovf (wr_ovf), .unf (wr_unf)
  );

  assign cfg_wr   = csb.reg_wr_en && (csb.reg_offset <= OS_CNT_OFS);
  assign apply_ok = idle && (rd_live == '0) && (wr_live == '0);

  // next shadow values feed both the shadow flops and a same-cycle apply
  always_comb begin
    rd_wt_nxt  = rd_wt_shd;
    wr_wt_nxt  = wr_wt_shd;
    rd_lim_nxt = rd_lim_shd;
    wr_lim_nxt = wr_lim_shd;
    if (csb.reg_wr_en) begin
      for (int i = 0; i < NUM_RD; i++)
        if (csb.reg_offset == RD_WEIGHT_BASE + 12'(4 * (i / 4)))
          rd_wt_nxt[8*i +: 8] = csb.reg_wr_data[8*(i%4) +: 8];
      for (int i = 0; i < NUM_WR; i++)
        if (csb.reg_offset == WR_WEIGHT_BASE + 12'(4 * (i / 4)))
          wr_wt_nxt[8*i +: 8] = csb.reg_wr_data[8*(i%4) +: 8];
      if (csb.reg_offset == OS_CNT_OFS) begin
        rd_lim_nxt = csb.reg_wr_data[OS_CNT_W-1:0];
        wr_lim_nxt = csb.reg_wr_data[8 +: OS_CNT_W];
      end
    end
  end

  always_comb begin
    err_set             = '0;
    err_set[ERR_RD_OVF] = rd_ovf;
    err_set[ERR_RD_UNF] = rd_unf;
    err_set[ERR_WR_OVF] = wr_ovf;
    err_set[ERR_WR_UNF] = wr_unf;
    err_clr = (csb.reg_wr_en && csb.reg_offset == ERR_OFS) ? csb.reg_wr_data[3:0] : 4'h0;
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) begin
      state      <= ST_SYNC;
      rd_wt_shd  <= {NUM_RD{WEIGHT_RST}};
      wr_wt_shd  <= {NUM_WR{WEIGHT_RST}};
      rd_lim_shd <= OS_LIM_RST[OS_CNT_W-1:0];
      wr_lim_shd <= OS_LIM_RST[OS_CNT_W-1:0];
      rd_weight  <= {NUM_RD{WEIGHT_RST}};
      wr_weight  <= {NUM_WR{WEIGHT_RST}};
      rd_os_cnt  <= OS_LIM_RST[OS_CNT_W-1:0];
      wr_os_cnt  <= OS_LIM_RST[OS_CNT_W-1:0];
      err        <= '0;
      err_intr   <= 1'b0;
    end else begin
      rd_wt_shd  <= rd_wt_nxt;
      wr_wt_shd  <= wr_wt_nxt;
      rd_lim_shd <= rd_lim_nxt;
      wr_lim_shd <= wr_lim_nxt;
      err        <= (err & ~err_clr) | err_set;
      err_intr   <= |err;
      case (state)
        ST_SYNC: if (cfg_wr) state <= ST_PENDING;
        ST_PENDING: begin
          if (apply_ok) begin
            state     <= ST_SYNC;
            rd_weight <= rd_wt_nxt;
            wr_weight <= wr_wt_nxt;
            rd_os_cnt <= rd_lim_nxt;
            wr_os_cnt <= wr_lim_nxt;
          end
        end
        default: state <= ST_SYNC;
      endcase
    end
  end

`ifdef MCIF_CSB_PERF_EN
  logic [31:0] rd_req_cnt, wr_req_cnt;

  // a clear beats a same-cycle issue
  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) begin
      rd_req_cnt <= '0;
      wr_req_cnt <= '0;
    end else begin
      if (csb.reg_wr_en && csb.reg_offset == RD_REQ_CNT_OFS) rd_req_cnt <= '0;
      else if (rd_req_issue)                                 rd_req_cnt <= rd_req_cnt + 32'd1;
      if (csb.reg_wr_en && csb.reg_offset == WR_REQ_CNT_OFS) wr_req_cnt <= '0;
      else if (wr_req_issue)                                 wr_req_cnt <= wr_req_cnt + 32'd1;
    end
  end
`endif

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_RD; i++)
      if (csb.reg_offset == RD_WEIGHT_BASE + 12'(4 * (i / 4)))
        rd_data[8*(i%4) +: 8] = rd_wt_shd[8*i +: 8];
    for (int i = 0; i < NUM_WR; i++)
      if (csb.reg_offset == WR_WEIGHT_BASE + 12'(4 * (i / 4)))
        rd_data[8*(i%4) +: 8] = wr_wt_shd[8*i +: 8];
    case (csb.reg_offset)
      OS_CNT_OFS: begin
        rd_data[OS_CNT_W-1:0]  = rd_lim_shd;
        rd_data[8 +: OS_CNT_W] = wr_lim_shd;
      end
      STATUS_OFS: begin
        rd_data[24 +: OS_CNT_W] = wr_live;
        rd_data[16 +: OS_CNT_W] = rd_live;
        rd_data[9]              = (state == ST_PENDING);
        rd_data[8]              = idle;
      end
      ERR_OFS: rd_data[3:0] = err;
`ifdef MCIF_CSB_PERF_EN
      RD_REQ_CNT_OFS: rd_data = rd_req_cnt;
      WR_REQ_CNT_OFS: rd_data = wr_req_cnt;
`endif
      default: ;
    endcase
  end

  assign csb.reg_rd_data = rd_data;

endmodule

// File: tb/tb_nv_nvdla_mcif_csb_reg_gen.sv
// Self-checking bench for nv_nvdla_mcif_csb_reg_gen: reset table, directed corner sequences, random traffic vs model.
module tb_nv_nvdla_mcif_csb_reg_gen;
  localparam int NUM_RD = 12, NUM_WR = 8, OS_CNT_W = 8, OSMAX = 255;

  logic nvdla_core_clk = 1'b0;
  logic nvdla_core_rstn = 1'b0;
  logic idle = 1'b1;
  logic rd_req_issue = 1'b0, rd_rsp_done = 1'b0, wr_req_issue = 1'b0, wr_rsp_done = 1'b0;
  logic [8*NUM_RD-1:0] rd_weight;
  logic [8*NUM_WR-1:0] wr_weight;
  logic [OS_CNT_W-1:0] rd_os_cnt, wr_os_cnt;
  logic err_intr;

  nv_nvdla_mcif_csb_reg_gen_if csb();

  nv_nvdla_mcif_csb_reg_gen #(.NUM_RD(NUM_RD), .NUM_WR(NUM_WR), .OS_CNT_W(OS_CNT_W)) dut (
    .nvdla_core_clk (nvdla_core_clk), .nvdla_core_rstn (nvdla_core_rstn), .csb (csb.slave),
    .idle (idle), .rd_req_issue (rd_req_issue), .rd_rsp_done (rd_rsp_done),
    .wr_req_issue (wr_req_issue), .wr_rsp_done (wr_rsp_done),
    .rd_weight (rd_weight), .wr_weight (wr_weight), .rd_os_cnt (rd_os_cnt),
    .wr_os_cnt (wr_os_cnt), .err_intr (err_intr)
  );

  always #5 nvdla_core_clk = ~nvdla_core_clk;

  int total = 0, bad = 0;

  // reference model: plain integer state derived from the register rules
  int m_rd_shd[NUM_RD], m_rd_act[NUM_RD], m_wr_shd[NUM_WR], m_wr_act[NUM_WR];
  int m_rlim_shd, m_wlim_shd, m_rlim_act, m_wlim_act, m_rlive, m_wlive;
  bit m_pend, m_intr;
  bit [3:0] m_err;
  int unsigned m_rperf, m_wperf;

  typedef struct { int ofs; logic [31:0] exp; } rd_vec_t;

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic void mdl_rst();
    foreach (m_rd_shd[i]) begin m_rd_shd[i] = 1; m_rd_act[i] = 1; end
    foreach (m_wr_shd[i]) begin m_wr_shd[i] = 1; m_wr_act[i] = 1; end
    m_rlim_shd = OSMAX; m_wlim_shd = OSMAX; m_rlim_act = OSMAX; m_wlim_act = OSMAX;
    m_rlive = 0; m_wlive = 0; m_pend = 0; m_intr = 0; m_err = 0; m_rperf = 0; m_wperf = 0;
  endfunction

  function automatic logic [31:0] mdl_read(int ofs);
    logic [31:0] r = '0;
    if (ofs < 'h40 && ofs % 4 == 0) begin
      for (int j = 0; j < 4; j++) if (ofs + j < NUM_RD) r[8*j +: 8] = 8'(m_rd_shd[ofs+j]);
    end else if (ofs >= 'h40 && ofs < 'h80 && ofs % 4 == 0) begin
      for (int j = 0; j < 4; j++) if (ofs - 'h40 + j < NUM_WR) r[8*j +: 8] = 8'(m_wr_shd[ofs-'h40+j]);
    end else if (ofs == 'h80) r = m_wlim_shd * 256 + m_rlim_shd;
    else if (ofs == 'h84) r = m_wlive * 32'h0100_0000 + m_rlive * 32'h1_0000 + m_pend * 512 + idle * 256;
    else if (ofs == 'h88) r = 32'(m_err);
`ifdef MCIF_CSB_PERF_EN
    else if (ofs == 'h8C) r = m_rperf;
    else if (ofs == 'h90) r = m_wperf;
`endif
    return r;
  endfunction

  function automatic void mdl_step(bit we, int ofs, logic [31:0] d, bit id, bit ri, bit rdn, bit wi, bit wdn);
    bit cond, rovf, runf, wovf, wunf;
    bit [3:0] set, clr;
    if (we) begin
      if (ofs < 'h40 && ofs % 4 == 0)
        for (int j = 0; j < 4; j++) if (ofs + j < NUM_RD) m_rd_shd[ofs+j] = (d >> (8*j)) & 255;
      if (ofs >= 'h40 && ofs < 'h80 && ofs % 4 == 0)
        for (int j = 0; j < 4; j++) if (ofs - 'h40 + j < NUM_WR) m_wr_shd[ofs-'h40+j] = (d >> (8*j)) & 255;
      if (ofs == 'h80) begin m_rlim_shd = d & 255; m_wlim_shd = (d >> 8) & 255; end
    end
    cond = id && m_rlive == 0 && m_wlive == 0;
    rovf = ri && !rdn && m_rlive == OSMAX;  runf = rdn && !ri && m_rlive == 0;
    wovf = wi && !wdn && m_wlive == OSMAX;  wunf = wdn && !wi && m_wlive == 0;
    if (!rovf && !runf) m_rlive = m_rlive + ri - rdn;
    if (!wovf && !wunf) m_wlive = m_wlive + wi - wdn;
    set = {wunf, wovf, runf, rovf};
    clr = (we && ofs == 'h88) ? d[3:0] : 4'h0;
    m_intr = (m_err != 0);
    m_err = (m_err & ~clr) | set;
    if (m_pend && cond) begin
      m_rd_act = m_rd_shd; m_wr_act = m_wr_shd;
      m_rlim_act = m_rlim_shd; m_wlim_act = m_wlim_shd; m_pend = 0;
    end else if (we && ofs <= 'h80) m_pend = 1;
    if (we && ofs == 'h8C) m_rperf = 0; else m_rperf += ri;
    if (we && ofs == 'h90) m_wperf = 0; else m_wperf += wi;
  endfunction

  task automatic step(bit we, int ofs, logic [31:0] d, bit id, bit ri, bit rdn, bit wi, bit wdn);
    csb.reg_wr_en = we; csb.reg_offset = 12'(ofs); csb.reg_wr_data = d; idle = id;
    rd_req_issue = ri; rd_rsp_done = rdn; wr_req_issue = wi; wr_rsp_done = wdn;
    mdl_step(we, ofs, d, id, ri, rdn, wi, wdn);
    @(posedge nvdla_core_clk); #1;
    csb.reg_wr_en = 1'b0; rd_req_issue = 1'b0; rd_rsp_done = 1'b0; wr_req_issue = 1'b0; wr_rsp_done = 1'b0;
  endtask

  task automatic idle_cyc(bit id);
    step(0, 'h100, 32'h0, id, 0, 0, 0, 0);
  endtask

  task automatic rd_at(int ofs, output logic [31:0] v);
    csb.reg_offset = 12'(ofs); #1; v = csb.reg_rd_data;
  endtask

  task automatic do_reset();
    nvdla_core_rstn = 1'b0; csb.reg_wr_en = 1'b0; idle = 1'b1;
    rd_req_issue = 1'b0; rd_rsp_done = 1'b0; wr_req_issue = 1'b0; wr_rsp_done = 1'b0;
    repeat (2) @(posedge nvdla_core_clk);
    #1; nvdla_core_rstn = 1'b1; mdl_rst();
  endtask

  task automatic chk_outs(string tag);
    logic [127:0] er = '0, ew = '0;
    foreach (m_rd_act[i]) er[8*i +: 8] = 8'(m_rd_act[i]);
    foreach (m_wr_act[i]) ew[8*i +: 8] = 8'(m_wr_act[i]);
    chk({tag, " rd_weight"}, 128'(rd_weight), er);
    chk({tag, " wr_weight"}, 128'(wr_weight), ew);
    chk({tag, " rd_os_cnt"}, 128'(rd_os_cnt), 128'(m_rlim_act));
    chk({tag, " wr_os_cnt"}, 128'(wr_os_cnt), 128'(m_wlim_act));
    chk({tag, " err_intr"}, 128'(err_intr), 128'(m_intr));
  endtask

  initial begin
    rd_vec_t rst_tab[13];
    int ofs_tab[15];
    logic [31:0] v;
    logic [31:0] perf_exp;
    csb.reg_wr_en = 1'b0; csb.reg_offset = '0; csb.reg_wr_data = '0;
    mdl_rst();
    rst_tab = '{'{'h000, 32'h01010101}, '{'h004, 32'h01010101}, '{'h008, 32'h01010101},
                '{'h00C, 32'h0}, '{'h040, 32'h01010101}, '{'h044, 32'h01010101},
                '{'h048, 32'h0}, '{'h080, 32'h0000FFFF}, '{'h084, 32'h00000100},
                '{'h088, 32'h0}, '{'h08C, 32'h0}, '{'h090, 32'h0}, '{'h100, 32'h0}};
    ofs_tab = '{'h000, 'h004, 'h008, 'h00C, 'h040, 'h044, 'h048, 'h080,
                'h084, 'h088, 'h08C, 'h090, 'h100, 'h03C, 'h07C};

    // 1: reset values
    do_reset();
    for (int i = 0; i < 13; i++) begin
      rd_at(rst_tab[i].ofs, v);
      chk($sformatf("reset_rd_%03h", rst_tab[i].ofs), 128'(v), 128'(rst_tab[i].exp));
      idle_cyc(1);
    end
    chk_outs("reset");
    chk("reset_rd_weight_const", 128'(rd_weight), 128'({NUM_RD{8'h01}}));

    // 2: shadow write held until idle
    step(1, 'h000, 32'h04030201, 0, 0, 0, 0, 0);
    rd_at('h000, v); chk("t2_shadow_rd", 128'(v), 128'(32'h04030201));
    chk("t2_active_held", 128'(rd_weight[31:0]), 128'(32'h01010101));
    rd_at('h084, v); chk("t2_status_pend", 128'(v), 128'(32'h00000200));
    idle_cyc(0);
    chk("t2_still_held", 128'(rd_weight[31:0]), 128'(32'h01010101));
    idle_cyc(1);
    chk("t2_applied", 128'(rd_weight[31:0]), 128'(32'h04030201));
    rd_at('h084, v); chk("t2_status_sync", 128'(v), 128'(32'h00000100));

    // 3: live reads block the apply
    step(0, 'h100, 0, 1, 1, 0, 0, 0);
    step(0, 'h100, 0, 1, 1, 0, 0, 0);
    step(0, 'h100, 0, 1, 1, 1, 0, 0);
    step(0, 'h100, 0, 1, 1, 0, 0, 0);
    rd_at('h084, v); chk("t3_rd_live3", 128'(v), 128'(32'h00030100));
    step(1, 'h040, 32'h0a0b0c0d, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 'h100, 0, 1, 0, 1, 0, 0);
      chk($sformatf("t3_blocked_%0d", i), 128'(wr_weight[31:0]), 128'(32'h01010101));
    end
    idle_cyc(1);
    chk("t3_applied", 128'(wr_weight[31:0]), 128'(32'h0a0b0c0d));
    chk_outs("t3");

    // 4: underflow and W1C
    step(0, 'h100, 0, 1, 0, 1, 0, 0);
    rd_at('h088, v); chk("t4_err_unf", 128'(v), 128'(32'h2));
    chk("t4_intr_lag", 128'(err_intr), 128'(1'b0));
    idle_cyc(1);
    chk("t4_intr_set", 128'(err_intr), 128'(1'b1));
    step(1, 'h088, 32'h2, 1, 0, 1, 0, 0);
    rd_at('h088, v); chk("t4_set_wins", 128'(v), 128'(32'h2));
    step(1, 'h088, 32'h2, 1, 0, 0, 0, 0);
    rd_at('h088, v); chk("t4_cleared", 128'(v), 128'(32'h0));
    idle_cyc(1);
    chk("t4_intr_fall", 128'(err_intr), 128'(1'b0));

    // 5: write overflow, then reset while pending
    for (int i = 0; i < 255; i++) step(0, 'h100, 0, 1, 0, 0, 1, 0);
    rd_at('h084, v); chk("t5_wr_live_max", 128'(v[31:24]), 128'(8'hFF));
    step(0, 'h100, 0, 1, 0, 0, 1, 0);
    rd_at('h084, v); chk("t5_wr_live_sat", 128'(v[31:24]), 128'(8'hFF));
    rd_at('h088, v); chk("t5_err_ovf", 128'(v), 128'(32'h4));
    step(1, 'h080, 32'h00001234, 1, 0, 0, 0, 0);
    rd_at('h084, v); chk("t5_pending", 128'(v[9]), 128'(1'b1));
    chk_outs("t5_pre");
    do_reset();
    chk_outs("t5_post");
    chk("t5_rd_os_cnt", 128'(rd_os_cnt), 128'(8'hFF));
    rd_at('h084, v); chk("t5_status", 128'(v), 128'(32'h00000100));
    rd_at('h080, v); chk("t5_os_cnt_rd", 128'(v), 128'(32'h0000FFFF));
    rd_at('h088, v); chk("t5_err_rd", 128'(v), 128'(32'h0));

    // 6: performance counters
    for (int i = 0; i < 10; i++) step(0, 'h100, 0, 1, 1, 0, 0, 0);
`ifdef MCIF_CSB_PERF_EN
    perf_exp = 32'd10;
`else
    perf_exp = 32'd0;
`endif
    rd_at('h08C, v); chk("t6_rd_perf", 128'(v), 128'(perf_exp));
    step(1, 'h08C, 32'h5, 1, 0, 0, 0, 0);
    rd_at('h08C, v); chk("t6_perf_clr", 128'(v), 128'(32'h0));
    step(1, 'h08C, 32'h5, 1, 1, 0, 0, 0);
    rd_at('h08C, v); chk("t6_clr_wins", 128'(v), 128'(32'h0));
    for (int i = 0; i < 11; i++) step(0, 'h100, 0, 1, 0, 1, 0, 0);
    chk_outs("t6");

    // random traffic against the model
    for (int n = 0; n < 600; n++) begin
      bit we;
      int ofs;
      if (n == 300) do_reset();
      we  = ($urandom_range(0, 3) == 0);
      ofs = ofs_tab[$urandom_range(0, 14)];
      step(we, ofs, $urandom(), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0));
      chk_outs($sformatf("rnd%0d", n));
      ofs = ofs_tab[$urandom_range(0, 14)];
      rd_at(ofs, v);
      chk($sformatf("rnd%0d_rd_%03h", n, ofs), 128'(v), 128'(mdl_read(ofs)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
